// File: rtl/carbon_csr_init_pkg.sv
// carbon_csr_init_pkg: shared types for the CSR boot-table sequencer.
// State encoding, index/retry widths, and table size limit.
package carbon_csr_init_pkg;

  localparam int CARBON_CSR_INIT_MAX_ENTRIES = 256;
  localparam int IDX_W   = 8;
  localparam int RETRY_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    VERIFY,
    RELEASE,
    FAULT,
    DONE
  } state_t;

endpackage

// File: rtl/carbon_csr_init_seq.sv
// carbon_csr_init_seq: replays a CSR write table after reset, then runs the core.
// Optional readback check of each write: define CARBON_CSR_INIT_VERIFY_EN.
module carbon_csr_init_seq
  import carbon_csr_init_pkg::*;
#(
  parameter int N_ENTRIES = 6,
  parameter logic [((N_ENTRIES > 0) ? N_ENTRIES : 1)*32-1:0] INIT_ADDR = '0,
  parameter logic [((N_ENTRIES > 0) ? N_ENTRIES : 1)*32-1:0] INIT_DATA = '0,
  parameter int MAX_RETRIES = 1,
  parameter int TIMEOUT_CYC = 256,
  parameter bit HALT_ON_FAULT = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        csr_start,
  output logic        csr_write,
  output logic [31:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic        csr_busy,
  input  logic        csr_done,
  input  logic        csr_fault,
  input  logic [31:0] csr_rdata,
  output logic        halt_req,
  output logic        run_pulse,
  output logic        init_done,
  output logic        init_fault,
  output logic [7:0]  fault_index
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [RETRY_W-1:0] retry;
  logic [TW-1:0]      timer;
  logic               attempt_ok;
  logic               last;
  logic               timeout;

  // Table lookup follows the entry index; it only moves on success.
  assign csr_addr  = INIT_ADDR[idx*32 +: 32];
  assign csr_wdata = INIT_DATA[idx*32 +: 32];

  assign last    = (idx == IDX_W'(N_ENTRIES - 1));
  assign timeout = (timer == TW'(TIMEOUT_CYC - 1));

`ifdef CARBON_CSR_INIT_VERIFY_EN
  logic wr_q;
  assign csr_write  = wr_q;
  assign attempt_ok = !csr_fault && (wr_q || (csr_rdata == csr_wdata));
`else
  logic unused_rdata;
  assign csr_write    = 1'b1;
  assign attempt_ok   = !csr_fault;
  assign unused_rdata = ^csr_rdata;
`endif

  // Sequencer: issue, wait, retry or give up, then release the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      retry       <= '0;
      timer       <= '0;
      csr_start   <= 1'b0;
      halt_req    <= 1'b1;
      run_pulse   <= 1'b0;
      init_done   <= 1'b0;
      init_fault  <= 1'b0;
      fault_index <= '0;
`ifdef CARBON_CSR_INIT_VERIFY_EN
      wr_q        <= 1'b1;
`endif
    end else begin
      csr_start <= 1'b0;
      run_pulse <= 1'b0;
      unique case (state)
        IDLE: state <= (N_ENTRIES == 0) ? RELEASE : ISSUE;
        ISSUE: begin
          if (!csr_busy) begin
            csr_start <= 1'b1;
            timer     <= '0;
            state     <= WAIT;
`ifdef CARBON_CSR_INIT_VERIFY_EN
            wr_q      <= 1'b1;
`endif
          end
        end
`ifdef CARBON_CSR_INIT_VERIFY_EN
        VERIFY: begin
          if (!csr_busy) begin
            csr_start <= 1'b1;
            wr_q      <= 1'b0;
            timer     <= '0;
            state     <= WAIT;
          end
        end
`endif
        WAIT: begin
          timer <= timer + 1'b1;
          if (csr_done && attempt_ok) begin
`ifdef CARBON_CSR_INIT_VERIFY_EN
            if (wr_q) begin
              state <= VERIFY;
            end else begin
              retry <= '0;
              if (last) state <= RELEASE;
              else begin
                idx   <= idx + 1'b1;
                state <= ISSUE;
              end
            end
`else
            retry <= '0;
            if (last) state <= RELEASE;
            else begin
              idx   <= idx + 1'b1;
              state <= ISSUE;
            end
`endif
          end else if (csr_done || timeout) begin
            if (retry < RETRY_W'(MAX_RETRIES)) begin
              retry <= retry + 1'b1;
              state <= ISSUE;
            end else begin
              fault_index <= idx;
              init_fault  <= 1'b1;
              state       <= FAULT;
            end
          end
        end
        RELEASE: begin
          halt_req  <= 1'b0;
          run_pulse <= 1'b1;
          state     <= DONE;
        end
        FAULT: begin
          if (HALT_ON_FAULT) begin
            init_done <= 1'b1;
            state     <= DONE;
          end else begin
            state <= RELEASE;
          end
        end
        DONE: init_done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carbon_csr_init_seq.sv
// tb_carbon_csr_init_seq: directed scenario table against a 2-cycle CSR master model.
// Add CARBON_CSR_INIT_VERIFY_EN to also exercise the readback path.
module tb_carbon_csr_init_seq;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_start, csr_write;
  logic [31:0] csr_addr, csr_wdata;
  logic        csr_busy = 1'b0;
  logic        csr_done = 1'b0;
  logic        csr_fault = 1'b0;
  logic [31:0] csr_rdata = '0;
  logic        halt_req, run_pulse, init_done, init_fault;
  logic [7:0]  fault_index;

  always #5 clk = ~clk;

  carbon_csr_init_seq #(
    .N_ENTRIES    (N),
    .INIT_ADDR    ({32'h0000_0108, 32'h0000_0104, 32'h0000_0100}),
    .INIT_DATA    ({32'hDEAD_BEEF, 32'hA5A5_0002, 32'h0000_0001}),
    .MAX_RETRIES  (1),
    .TIMEOUT_CYC  (16),
    .HALT_ON_FAULT(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_start  (csr_start),
    .csr_write  (csr_write),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_busy   (csr_busy),
    .csr_done   (csr_done),
    .csr_fault  (csr_fault),
    .csr_rdata  (csr_rdata),
    .halt_req   (halt_req),
    .run_pulse  (run_pulse),
    .init_done  (init_done),
    .init_fault (init_fault),
    .fault_index(fault_index)
  );

  // scenario knobs (written by the test only)
  int once_idx   = -1;
  int always_idx = -1;
  bit hang       = 1'b0;
  bit corrupt_rd = 1'b0;
  bit inject     = 1'b0;

  // master model / monitor state (written by the model only)
  int          cyc = 0;
  int          wr_cnt, run_cnt, edge_bad, cnt, ei;
  int          wr_cyc [8];
  logic [31:0] wr_addr [8];
  int          att [N];
  logic [31:0] mem [N];
  bit          prev_halt, f_q, corrupt_used;
  logic [31:0] r_q;

  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // CSR master: answers 2 cycles after start, faults by scenario
  always @(negedge clk) begin
    csr_done  = 1'b0;
    csr_fault = 1'b0;
    if (rst) begin
      csr_busy     = 1'b0;
      cnt          = 0;
      prev_halt    = 1'b1;
      wr_cnt       = 0;
      run_cnt      = 0;
      edge_bad     = 0;
      corrupt_used = 1'b0;
      for (int i = 0; i < N; i++) begin
        att[i] = 0;
        mem[i] = '0;
      end
    end else begin
      if (inject) csr_done = 1'b1;
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          csr_done  = 1'b1;
          csr_fault = f_q;
          csr_rdata = r_q;
          csr_busy  = 1'b0;
        end
      end
      if (run_pulse) begin
        run_cnt++;
        if (halt_req || !prev_halt) edge_bad++;
      end
      prev_halt = halt_req;
      if (csr_start) begin
        ei = int'((csr_addr - 32'h100) >> 2);
        if (ei < 0 || ei >= N) ei = 0;
        if (csr_write) begin
          if (wr_cnt < 8) begin
            wr_addr[wr_cnt] = csr_addr;
            wr_cyc[wr_cnt]  = cyc;
          end
          wr_cnt++;
          att[ei]++;
          mem[ei] = csr_wdata;
          f_q = (ei == always_idx) || (ei == once_idx && att[ei] == 1);
        end else begin
          f_q = 1'b0;
          r_q = (corrupt_rd && ei == 0 && !corrupt_used) ? 32'h2 : mem[ei];
          if (corrupt_rd && ei == 0) corrupt_used = 1'b1;
        end
        if (!hang) begin
          csr_busy = 1'b1;
          cnt      = 2;
        end
      end
    end
  end

  typedef struct {
    string name;
    int    once;
    int    alw;
    bit    hang;
    int    n_wr;
    int    seq [4];
    bit    fault;
    int    fidx;
    bit    halt;
    int    runs;
    int    gap;
  } vec_t;

  vec_t v [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_run(input int once, input int alw, input bit hg,
                           input bit crd);
    rst = 1'b1;
    once_idx   = once;
    always_idx = alw;
    hang       = hg;
    corrupt_rd = crd;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_to_done(input string nm);
    for (int k = 0; k < 300 && !init_done; k++) begin
      @(posedge clk);
      #2;
    end
    chk({nm, " done_in_budget"}, 32'(init_done), 32'd1);
    repeat (6) @(posedge clk);
    #2;
  endtask

  initial begin
    v[0] = '{"normal", -1, -1, 1'b0, 3, '{0, 1, 2, 0}, 1'b0, 0, 1'b0, 1, 0};
    v[1] = '{"once1",   1, -1, 1'b0, 4, '{0, 1, 1, 2}, 1'b0, 0, 1'b0, 1, 0};
    v[2] = '{"always2",-1,  2, 1'b0, 4, '{0, 1, 2, 2}, 1'b1, 2, 1'b1, 0, 0};
    v[3] = '{"hang",   -1, -1, 1'b1, 2, '{0, 0, 0, 0}, 1'b1, 0, 1'b1, 0, 17};

    // reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst csr_start",   32'(csr_start),   32'd0);
    chk("rst csr_write",   32'(csr_write),   32'd1);
    chk("rst csr_addr",    csr_addr,         32'h100);
    chk("rst csr_wdata",   csr_wdata,        32'h1);
    chk("rst halt_req",    32'(halt_req),    32'd1);
    chk("rst run_pulse",   32'(run_pulse),   32'd0);
    chk("rst init_done",   32'(init_done),   32'd0);
    chk("rst init_fault",  32'(init_fault),  32'd0);
    chk("rst fault_index", 32'(fault_index), 32'd0);

    for (int i = 0; i < 4; i++) begin
      start_run(v[i].once, v[i].alw, v[i].hang, 1'b0);
      run_to_done(v[i].name);
      chk({v[i].name, " writes"}, 32'(wr_cnt), 32'(v[i].n_wr));
      for (int j = 0; j < v[i].n_wr && j < 4; j++)
        chk($sformatf("%s addr%0d", v[i].name, j), wr_addr[j],
            32'h100 + 32'(4 * v[i].seq[j]));
      chk({v[i].name, " init_fault"}, 32'(init_fault), 32'(v[i].fault));
      chk({v[i].name, " fault_index"}, 32'(fault_index), 32'(v[i].fidx));
      chk({v[i].name, " halt_req"}, 32'(halt_req), 32'(v[i].halt));
      chk({v[i].name, " run_pulses"}, 32'(run_cnt), 32'(v[i].runs));
      chk({v[i].name, " halt_run_edge"}, 32'(edge_bad), 32'd0);
      if (v[i].gap != 0)
        chk({v[i].name, " retry_gap"}, 32'(wr_cyc[1] - wr_cyc[0]),
            32'(v[i].gap));
    end

    // late csr_done after give-up must not restart anything
    @(posedge clk);
    #2 inject = 1'b1;
    @(posedge clk);
    #2 inject = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("late writes",      32'(wr_cnt),      32'd2);
    chk("late init_fault",  32'(init_fault),  32'd1);
    chk("late fault_index", 32'(fault_index), 32'd0);
    chk("late halt_req",    32'(halt_req),    32'd1);
    chk("late runs",        32'(run_cnt),     32'd0);

    // reset while waiting on entry 1
    start_run(-1, -1, 1'b0, 1'b0);
    for (int k = 0; k < 100 && wr_cnt < 2; k++) begin
      @(posedge clk);
      #2;
    end
    chk("midrst reached_entry1", 32'(wr_cnt), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst csr_start", 32'(csr_start), 32'd0);
    chk("midrst csr_addr",  csr_addr,       32'h100);
    chk("midrst halt_req",  32'(halt_req),  32'd1);
    chk("midrst init_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_to_done("midrst");
    chk("midrst writes", 32'(wr_cnt),  32'd3);
    chk("midrst first",  wr_addr[0],   32'h100);
    chk("midrst runs",   32'(run_cnt), 32'd1);

`ifdef CARBON_CSR_INIT_VERIFY_EN
    // bad readback of entry 0 retries the write
    start_run(-1, -1, 1'b0, 1'b1);
    run_to_done("verify");
    chk("verify writes",     32'(wr_cnt),     32'd4);
    chk("verify addr1",      wr_addr[1],      32'h100);
    chk("verify init_fault", 32'(init_fault), 32'd0);
    chk("verify runs",       32'(run_cnt),    32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
